// File: rtl/divergent_manager.sv
// Per-core execution manager: per-thread PCs plus a live mask, scheduling the
// lowest live PC each instruction so divergent threads reconverge at the minimum PC.
module divergent_manager #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int PC_BITS           = 8
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [$clog2(THREADS_PER_BLOCK):0]     thread_count,
    input  logic [2:0]                             fetcher_state,
    input  logic                                   decoded_ret,
    input  logic [2*THREADS_PER_BLOCK-1:0]         lsu_state,
    input  logic [PC_BITS*THREADS_PER_BLOCK-1:0]   next_pc,
    output logic [PC_BITS-1:0]                     current_pc,
    output logic [THREADS_PER_BLOCK-1:0]           thread_mask,
    output logic [3:0]                             core_state,
    output logic                                   done
);
    localparam int T = THREADS_PER_BLOCK;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        REQUEST  = 4'd3,
        WAIT     = 4'd4,
        EXECUTE  = 4'd5,
        UPDATE   = 4'd6,
        DONE     = 4'd7,
        SCHEDULE = 4'd8
    } state_t;

    state_t                    state_q, state_d;
    logic [PC_BITS-1:0]        cur_pc_q, cur_pc_d;
    logic [T-1:0]              mask_q, mask_d;
    logic [T-1:0]              live_q, live_d;
    logic [T-1:0][PC_BITS-1:0] pc_q, pc_d;
    logic                      done_q, done_d;

    logic [PC_BITS-1:0]        min_pc;
    logic [T-1:0]              at_min;
    logic                      lsu_busy;

    // Starting from all-ones keeps the search correct when every live PC is the max value.
    always_comb begin
        min_pc = '1;
        for (int i = 0; i < T; i++) begin
            if (live_q[i] && (pc_q[i] < min_pc)) min_pc = pc_q[i];
        end
        at_min = '0;
        for (int i = 0; i < T; i++) begin
            at_min[i] = live_q[i] && (pc_q[i] == min_pc);
        end
    end

    always_comb begin
        lsu_busy = 1'b0;
        for (int i = 0; i < T; i++) begin
            if (mask_q[i] && ((lsu_state[2*i +: 2] == 2'b01) || (lsu_state[2*i +: 2] == 2'b10)))
                lsu_busy = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        cur_pc_d = cur_pc_q;
        mask_d   = mask_q;
        live_d   = live_q;
        pc_d     = pc_q;
        done_d   = done_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    pc_d = '0;
                    // Lanes are all below T, so this also clamps an oversized count.
                    for (int i = 0; i < T; i++) live_d[i] = (i < int'(thread_count));
                    state_d = SCHEDULE;
                end
            end
            SCHEDULE: begin
                if (live_q == '0) begin
                    done_d  = 1'b1;
                    mask_d  = '0;
                    state_d = DONE;
                end else begin
                    cur_pc_d = min_pc;
                    mask_d   = at_min;
                    state_d  = FETCH;
                end
            end
            FETCH:   if (fetcher_state == 3'b010) state_d = DECODE;
            DECODE:  state_d = REQUEST;
            REQUEST: state_d = WAIT;
            WAIT:    if (!lsu_busy) state_d = EXECUTE;
            EXECUTE: state_d = UPDATE;
            UPDATE: begin
                for (int i = 0; i < T; i++) begin
                    if (mask_q[i]) begin
                        if (decoded_ret) live_d[i] = 1'b0;
                        else             pc_d[i]   = next_pc[i*PC_BITS +: PC_BITS];
                    end
                end
                state_d = SCHEDULE;
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cur_pc_q <= '0;
            mask_q   <= '0;
            live_q   <= '0;
            pc_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_pc_q <= cur_pc_d;
            mask_q   <= mask_d;
            live_q   <= live_d;
            pc_q     <= pc_d;
            done_q   <= done_d;
        end
    end

    assign current_pc  = cur_pc_q;
    assign thread_mask = mask_q;
    assign core_state  = state_q;
    assign done        = done_q;
endmodule

// File: tb/tb_divergent_manager.sv
// Scoreboard bench for divergent_manager: a min-PC thread model predicts the
// (pc, mask) schedule; a negedge monitor checks it plus FETCH/WAIT/done behaviour.
module tb_divergent_manager;
    localparam int T   = 4;
    localparam int PCB = 8;
    localparam int NPC = 256;
    localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_WAIT = 4'd4,
                           S_EXEC = 4'd5, S_DONE = 4'd7, S_SCHED = 4'd8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [2:0]       thread_count = 3'd0;
    logic [2:0]       fetcher_state = 3'b001;
    logic             decoded_ret = 1'b0;
    logic [2*T-1:0]   lsu_state = '0;
    logic [PCB*T-1:0] next_pc = '0;
    logic [PCB-1:0]   current_pc;
    logic [T-1:0]     thread_mask;
    logic [3:0]       core_state;
    logic             done;

    divergent_manager #(.THREADS_PER_BLOCK(T), .PC_BITS(PCB)) dut (
        .clk(clk), .reset(reset), .start(start), .thread_count(thread_count),
        .fetcher_state(fetcher_state), .decoded_ret(decoded_ret), .lsu_state(lsu_state),
        .next_pc(next_pc), .current_pc(current_pc), .thread_mask(thread_mask),
        .core_state(core_state), .done(done)
    );

    always #5 clk = ~clk;

    // Program: per-thread next PC for each PC, and which PCs hold RET.
    int  nxt [T][NPC];
    bit  is_ret [NPC];
    int  exp_pc[$];
    int  exp_mask[$];

    int  n_checks = 0;
    int  n_fail = 0;
    bit  mon_en = 0;
    bit  per_chk = 0;
    bit  start_noise = 0;
    int  lsu_mode = 0;
    int  lane_stuck = -1;
    int  stall_len = 0;
    int  launch_cnt = 0;
    int  launch_done = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void set_linear();
        for (int p = 0; p < NPC; p++) begin
            is_ret[p] = 1'b0;
            for (int i = 0; i < T; i++) nxt[i][p] = (p + 1) % NPC;
        end
    endfunction

    function automatic void set_random_prog();
        set_linear();
        for (int p = 0; p < 16; p++) begin
            is_ret[p] = ($urandom_range(0, 5) == 0);
            for (int i = 0; i < T; i++) begin
                nxt[i][p] = p + 1 + int'($urandom_range(0, 2));
                if (nxt[i][p] > 15) nxt[i][p] = 15;
            end
        end
        is_ret[15] = 1'b1;
    endfunction

    // Thread-level reference: run every live thread at the lowest PC until none remain.
    task automatic build_model(input int tc);
        int pc [T];
        bit live [T];
        int n, m, mask;
        n = (tc > T) ? T : tc;
        exp_pc.delete();
        exp_mask.delete();
        for (int i = 0; i < T; i++) begin
            pc[i] = 0;
            live[i] = (i < n);
        end
        for (int step = 0; step < 4000; step++) begin
            m = NPC;
            for (int i = 0; i < T; i++) if (live[i] && pc[i] < m) m = pc[i];
            if (m == NPC) break;
            mask = 0;
            for (int i = 0; i < T; i++) if (live[i] && pc[i] == m) mask |= (1 << i);
            exp_pc.push_back(m);
            exp_mask.push_back(mask);
            for (int i = 0; i < T; i++) begin
                if (mask[i]) begin
                    if (is_ret[m]) live[i] = 1'b0;
                    else           pc[i] = nxt[i][m];
                end
            end
        end
    endtask

    // Stimulus driver: reacts to the DUT state just after each rising edge.
    int        fcnt = 0;
    int        wcnt = 0;
    logic [1:0] lane;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            fcnt = (core_state == S_FETCH) ? fcnt + 1 : 0;
            wcnt = (core_state == S_WAIT) ? wcnt + 1 : 0;
            fetcher_state = (core_state == S_FETCH && fcnt > stall_len) ? 3'b010 : 3'b001;
            for (int i = 0; i < T; i++) begin
                lane = 2'b00;
                if (lsu_mode == 1) begin
                    if ($urandom_range(0, 3) == 0) lane = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
                    else                           lane = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
                end else if (lsu_mode == 2 && i == 1) begin
                    lane = (core_state == S_WAIT && wcnt <= 5) ? 2'b10 : 2'b00;
                end
                if (i == lane_stuck) lane = 2'b01;
                lsu_state[2*i +: 2] = lane;
                next_pc[PCB*i +: PCB] = PCB'(nxt[i][current_pc]);
            end
            decoded_ret = is_ret[current_pc];
            if (launch_cnt != launch_done) begin
                start = 1'b1;
                launch_done = launch_cnt;
            end else begin
                start = start_noise && (core_state != S_IDLE) && ($urandom_range(0, 7) == 0);
            end
        end
    end

    // Monitor: compares against the scoreboard and checks per-cycle transitions.
    int             cyc = 0;
    int             last_sched = -1;
    bit             p_valid = 0;
    logic [3:0]     p_state;
    logic [T-1:0]   p_mask;
    logic [PCB-1:0] p_pc;
    logic [2:0]     p_fetch;
    logic [2*T-1:0] p_lsu;
    bit             busy;
    int             ep, em;
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!mon_en) begin
                p_valid = 0;
                last_sched = -1;
            end else begin
                if (p_valid) begin
                    if (core_state == S_FETCH && p_state != S_FETCH) begin
                        if (exp_pc.size() == 0) begin
                            check("sched_unexpected", 1, 0);
                        end else begin
                            ep = exp_pc.pop_front();
                            em = exp_mask.pop_front();
                            check("sched_pc", int'(current_pc), ep);
                            check("sched_mask", int'(thread_mask), em);
                        end
                    end
                    if (p_state == S_FETCH) begin
                        check("fetch_next", int'(core_state), int'((p_fetch == 3'b010) ? S_DECODE : S_FETCH));
                        if (core_state == S_FETCH) begin
                            check("fetch_pc_stable", int'(current_pc), int'(p_pc));
                            check("fetch_mask_stable", int'(thread_mask), int'(p_mask));
                        end
                    end
                    if (p_state == S_WAIT) begin
                        busy = 0;
                        for (int i = 0; i < T; i++)
                            if (p_mask[i] && (p_lsu[2*i +: 2] == 2'b01 || p_lsu[2*i +: 2] == 2'b10)) busy = 1;
                        check("wait_next", int'(core_state), int'(busy ? S_WAIT : S_EXEC));
                    end
                end
                check("done_flag", int'(done), int'(core_state == S_DONE));
                if (core_state == S_SCHED && (!p_valid || p_state != S_SCHED)) begin
                    if (per_chk && last_sched >= 0) check("sched_period", cyc - last_sched, 7);
                    last_sched = cyc;
                end
                p_state = core_state;
                p_mask  = thread_mask;
                p_pc    = current_pc;
                p_fetch = fetcher_state;
                p_lsu   = lsu_state;
                p_valid = 1;
            end
        end
    end

    task automatic wait_state(input logic [3:0] s, input int budget, input string nm);
        int k = 0;
        while (core_state != s && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(nm, int'(core_state), int'(s));
    endtask

    task automatic do_reset();
        mon_en = 0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_state", int'(core_state), int'(S_IDLE));
        check("rst_pc", int'(current_pc), 0);
        check("rst_mask", int'(thread_mask), 0);
        check("rst_done", int'(done), 0);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_prog(input int tc, input int lm, input int st, input bit noise, input bit per);
        logic [PCB-1:0] pc_at_done;
        do_reset();
        lsu_mode = lm;
        stall_len = st;
        start_noise = noise;
        per_chk = per;
        build_model(tc);
        thread_count = 3'(tc);
        mon_en = 1;
        launch_cnt++;
        wait_state(S_DONE, 20000, "reach_done");
        @(negedge clk);
        check("queue_drained", exp_pc.size(), 0);
        pc_at_done = current_pc;
        launch_cnt++;
        repeat (4) @(negedge clk);
        check("done_hold_state", int'(core_state), int'(S_DONE));
        check("done_hold_pc", int'(current_pc), int'(pc_at_done));
        check("done_hold_mask", int'(thread_mask), 0);
        mon_en = 0;
        per_chk = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_linear();
        // uniform flow, 7-cycle instruction period
        is_ret[3] = 1'b1;
        run_prog(4, 0, 0, 0, 1);

        // divergence at PC 2, reconvergence at 6
        set_linear();
        nxt[0][2] = 3; nxt[1][2] = 3; nxt[2][2] = 6; nxt[3][2] = 6;
        is_ret[7] = 1'b1;
        run_prog(4, 1, 2, 1, 0);

        // partial block, stuck unmasked lane, lane 1 waiting five cycles
        set_linear();
        is_ret[3] = 1'b1;
        lane_stuck = 3;
        run_prog(3, 2, 0, 0, 0);
        lane_stuck = -1;

        // staggered RET
        set_linear();
        nxt[2][1] = 5; nxt[3][1] = 5;
        is_ret[3] = 1'b1; is_ret[6] = 1'b1;
        run_prog(4, 1, 1, 1, 0);

        // fetch stall of ten cycles per instruction
        set_linear();
        is_ret[2] = 1'b1;
        run_prog(4, 0, 10, 0, 0);

        // wrapped branch target becomes the minimum
        set_linear();
        nxt[0][0] = 150;
        for (int i = 1; i < T; i++) begin
            nxt[i][0] = 100;
            nxt[i][100] = (100 + 200) % NPC;
        end
        is_ret[45] = 1'b1; is_ret[150] = 1'b1;
        run_prog(4, 0, 0, 0, 0);

        // oversized thread_count is clamped
        set_random_prog();
        run_prog(7, 1, 1, 1, 0);

        for (int r = 0; r < 6; r++) begin
            set_random_prog();
            run_prog(int'($urandom_range(0, 7)), 1, int'($urandom_range(0, 3)), 1, 0);
        end

        // thread_count=0: done two cycles after start
        do_reset();
        start_noise = 0;
        lsu_mode = 0;
        stall_len = 0;
        build_model(0);
        thread_count = 3'd0;
        mon_en = 1;
        @(negedge clk);
        launch_cnt++;
        @(negedge clk);
        @(negedge clk);
        check("tc0_sched", int'(core_state), int'(S_SCHED));
        check("tc0_done_early", int'(done), 0);
        @(negedge clk);
        check("tc0_state", int'(core_state), int'(S_DONE));
        check("tc0_done", int'(done), 1);
        check("tc0_pc", int'(current_pc), 0);
        mon_en = 0;

        // start ignored in WAIT, then reset mid-WAIT
        do_reset();
        set_linear();
        is_ret[3] = 1'b1;
        lsu_mode = 2;
        build_model(4);
        thread_count = 3'd4;
        mon_en = 1;
        launch_cnt++;
        wait_state(S_WAIT, 200, "reach_wait");
        launch_cnt++;
        repeat (2) @(negedge clk);
        check("start_in_wait", int'(core_state), int'(S_WAIT));
        mon_en = 0;
        #2;
        reset = 1'b0;
        #1;
        check("midwait_rst_state", int'(core_state), int'(S_IDLE));
        check("midwait_rst_pc", int'(current_pc), 0);
        check("midwait_rst_mask", int'(thread_mask), 0);
        check("midwait_rst_done", int'(done), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
